// File: rtl/music_sequencer.sv
// music_sequencer: plays (duration, half-period) note words from a 1-cycle-latency ROM; first tone 3 cycles after play.
// Define MUSIC_SEQUENCER_NOTE_GAP_EN for GAP_CYCLES of silence after every note; pause freezes only PLAY/GAP.
module music_sequencer #(
  parameter int ADDR_W          = 10,
  parameter int CYCLES_PER_BEAT = 1250000,
  parameter int GAP_CYCLES      = 125000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              play,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [23:0]       tone_switch_period,
  output logic              output_enable,
  output logic              busy,
  output logic              done
);

  localparam longint TICK_MAX = 64'd255 * longint'(CYCLES_PER_BEAT);
`ifdef MUSIC_SEQUENCER_NOTE_GAP_EN
  localparam longint CNT_MAX = (TICK_MAX > longint'(GAP_CYCLES)) ? TICK_MAX : longint'(GAP_CYCLES);
`else
  localparam longint CNT_MAX = TICK_MAX;
`endif
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PLAY
`ifdef MUSIC_SEQUENCER_NOTE_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  start_q, start_d;
  logic [23:0]        tone_q, tone_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      start_q <= '0;
      tone_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      tone_q  <= tone_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    start_d = start_q;
    tone_d  = tone_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    if (stop && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      tone_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (play && !stop) begin
            addr_d  = start_addr;
            start_d = start_addr;
            state_d = S_FETCH;
          end
        end
        S_FETCH: state_d = S_WAIT;
        S_WAIT: begin
          // rom_data holds the word addressed during FETCH
          if (rom_data[31:24] == 8'd0) begin
            if (loop_en) begin
              addr_d  = start_q;
              state_d = S_FETCH;
            end else begin
              tone_d  = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            tone_d  = rom_data[23:0];
            cnt_d   = CNT_W'(rom_data[31:24]) * CNT_W'(CYCLES_PER_BEAT);
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          if (!pause) begin
            if (cnt_q == CNT_W'(1)) begin
              addr_d = addr_q + 1'b1;
`ifdef MUSIC_SEQUENCER_NOTE_GAP_EN
              tone_d  = '0;
              cnt_d   = CNT_W'(GAP_CYCLES);
              state_d = S_GAP;
`else
              cnt_d   = '0;
              state_d = S_FETCH;
`endif
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
`ifdef MUSIC_SEQUENCER_NOTE_GAP_EN
        S_GAP: begin
          if (!pause) begin
            if (cnt_q == CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = S_FETCH;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rom_addr           = addr_q;
  assign tone_switch_period = tone_q;
  assign busy               = (state_q != S_IDLE);
  assign done               = done_q;
  assign output_enable      = (state_q == S_PLAY) && !pause;

endmodule

// File: tb/tb_music_sequencer.sv
// Bench for music_sequencer: expected per-cycle outputs derived from the note list, then compared each cycle.
`timescale 1ns/1ps
module tb_music_sequencer;

  localparam int AW   = 2;
  localparam int CPB  = 4;
  localparam int GAPC = 3;
`ifdef MUSIC_SEQUENCER_NOTE_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          play = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic [23:0]   tone_switch_period;
  logic          output_enable, busy, done;

  logic [31:0]   rom [4];

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  string tname = "";

  typedef struct packed {
    logic [23:0]   tone;
    logic          oe;
    logic          busy;
    logic          dn;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t tl[$];
  exp_t expq[$];

  music_sequencer #(.ADDR_W(AW), .CYCLES_PER_BEAT(CPB), .GAP_CYCLES(GAPC)) dut (
    .clk(clk), .rst_n(rst_n), .play(play), .stop(stop), .pause(pause), .loop_en(loop_en),
    .start_addr(start_addr), .rom_addr(rom_addr), .rom_data(rom_data),
    .tone_switch_period(tone_switch_period), .output_enable(output_enable),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void push(input int tone, input bit oe, input bit bz, input bit dn, input int addr);
    exp_t e;
    e.tone = 24'(tone);
    e.oe   = oe;
    e.busy = bz;
    e.dn   = dn;
    e.addr = AW'(addr);
    tl.push_back(e);
  endfunction

  // Expected trace, cycle 0 = first cycle after the edge that samples play.
  task automatic build(input int start, input bit lp, input int limit,
                       input int ps, input int pl, input int stop_at);
    int addr, tone, rem, d, p;
    bit pz;
    tl.delete();
    addr = start;
    tone = 0;
    while (tl.size() < limit) begin
      push(tone, 1'b0, 1'b1, 1'b0, addr);
      push(tone, 1'b0, 1'b1, 1'b0, addr);
      d = int'(rom[addr][31:24]);
      p = int'(rom[addr][23:0]);
      if (d == 0) begin
        if (lp) begin
          addr = start;
          continue;
        end
        push(0, 1'b0, 1'b0, 1'b1, addr);
        while (tl.size() < limit) push(0, 1'b0, 1'b0, 1'b0, addr);
        break;
      end
      tone = p;
      rem  = d * CPB;
      while (rem > 0) begin
        pz = (tl.size() >= ps) && (tl.size() < ps + pl);
        push(tone, !pz, 1'b1, 1'b0, addr);
        if (!pz) rem--;
      end
      addr = (addr + 1) % 4;
      if (GAP_ON) begin
        tone = 0;
        rem  = GAPC;
        while (rem > 0) begin
          pz = (tl.size() >= ps) && (tl.size() < ps + pl);
          push(0, 1'b0, 1'b1, 1'b0, addr);
          if (!pz) rem--;
        end
      end
    end
    while (tl.size() > limit) void'(tl.pop_back());
    if (stop_at >= 0) begin
      for (int i = stop_at + 1; i < limit; i++) begin
        tl[i].tone = '0;
        tl[i].oe   = 1'b0;
        tl[i].busy = 1'b0;
        tl[i].dn   = 1'b0;
        tl[i].addr = tl[stop_at].addr;
      end
    end
  endtask

  function automatic int count_oe();
    int n = 0;
    foreach (tl[i]) if (tl[i].oe) n++;
    return n;
  endfunction

  function automatic int count_done();
    int n = 0;
    foreach (tl[i]) if (tl[i].dn) n++;
    return n;
  endfunction

  function automatic int find_done();
    foreach (tl[i]) if (tl[i].dn) return i;
    return -1;
  endfunction

  // Drives the run described by tl; called at posedge+1 of an idle cycle.
  task automatic run(input int start, input bit lp, input int ps, input int pl, input int stop_at);
    foreach (tl[i]) expq.push_back(tl[i]);
    start_addr = AW'(start);
    loop_en    = lp;
    play       = 1'b1;
    @(posedge clk); #1;
    play   = 1'b0;
    chk_on = 1'b1;
    for (int t = 0; t < tl.size(); t++) begin
      pause = (t >= ps) && (t < ps + pl);
      stop  = (t == stop_at);
      play  = (t == stop_at);
      @(posedge clk); #1;
    end
    pause  = 1'b0;
    stop   = 1'b0;
    play   = 1'b0;
    chk_on = 1'b0;
    chk({tname, " trace fully consumed"}, 32'(expq.size()), 0);
    expq.delete();
  endtask

  int cyc_i = 0;
  always @(negedge clk) begin : cmp
    exp_t e;
    if (chk_on && expq.size() > 0) begin
      e = expq.pop_front();
      chk($sformatf("%s c%0d tone", tname, cyc_i), 32'(tone_switch_period), 32'(e.tone));
      chk($sformatf("%s c%0d oe",   tname, cyc_i), 32'(output_enable),      32'(e.oe));
      chk($sformatf("%s c%0d busy", tname, cyc_i), 32'(busy),               32'(e.busy));
      chk($sformatf("%s c%0d done", tname, cyc_i), 32'(done),               32'(e.dn));
      chk($sformatf("%s c%0d addr", tname, cyc_i), 32'(rom_addr),           32'(e.addr));
      cyc_i++;
    end else begin
      cyc_i = 0;
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) rom[i] = 32'd0;
    #2 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset busy", 32'(busy), 0);
    chk("reset oe",   32'(output_enable), 0);
    chk("reset tone", 32'(tone_switch_period), 0);
    chk("reset done", 32'(done), 0);
    chk("reset addr", 32'(rom_addr), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset idle", 32'(busy), 0);

    // single note then end of song
    tname = "single";
    rom[0] = {8'd2, 24'd100}; rom[1] = 32'd0;
    build(0, 1'b0, 24, -1, 0, -1);
    chk("single model tone", 32'(tl[2].tone), 100);
    chk("single model oe count", count_oe(), 8);
    chk("single model done idx", find_done(), GAP_ON ? 15 : 12);
    run(0, 1'b0, -1, 0, -1);

    // looping song; pause during FETCH/WAIT must not stall
    tname = "loop";
    build(0, 1'b1, 44, 0, 2, 40);
    chk("loop model no done", count_done(), 0);
    chk("loop model 2nd note", 32'(tl[GAP_ON ? 17 : 14].tone), 100);
    chk("loop model stopped", 32'(tl[41].busy), 0);
    run(0, 1'b1, 0, 2, 40);

    // pause mid-note
    tname = "pause";
    build(0, 1'b0, 24, 7, 4, -1);
    chk("pause model oe c6",  32'(tl[6].oe), 1);
    chk("pause model oe c7",  32'(tl[7].oe), 0);
    chk("pause model oe c11", 32'(tl[11].oe), 1);
    chk("pause model oe c13", 32'(tl[13].oe), 1);
    chk("pause model oe c14", 32'(tl[14].oe), 0);
    chk("pause model oe count", count_oe(), 8);
    chk("pause model done idx", find_done(), GAP_ON ? 19 : 16);
    run(0, 1'b0, 7, 4, -1);

    // stop with play mid-note
    tname = "stop";
    build(0, 1'b0, 10, -1, 0, 5);
    chk("stop model oe c5",   32'(tl[5].oe), 1);
    chk("stop model busy c6", 32'(tl[6].busy), 0);
    chk("stop model no done", count_done(), 0);
    run(0, 1'b0, -1, 0, 5);

    // address wrap 3 -> 0 with a rest note
    tname = "wrap";
    rom[3] = {8'd1, 24'd50}; rom[0] = {8'd1, 24'd0}; rom[1] = 32'd0;
    build(3, 1'b0, 24, -1, 0, -1);
    chk("wrap model tone c2", 32'(tl[2].tone), 50);
    chk("wrap model addr after wrap", 32'(tl[GAP_ON ? 9 : 6].addr), 0);
    chk("wrap model rest tone", 32'(tl[GAP_ON ? 11 : 8].tone), 0);
    chk("wrap model rest oe",   32'(tl[GAP_ON ? 11 : 8].oe), 1);
    chk("wrap model done idx",  find_done(), GAP_ON ? 20 : 14);
    run(3, 1'b0, -1, 0, -1);
    chk("wrap final addr", 32'(rom_addr), 1);

    // two consecutive notes
    tname = "two";
    rom[0] = {8'd2, 24'd100}; rom[1] = {8'd2, 24'd200}; rom[2] = 32'd0;
    build(0, 1'b0, 32, -1, 0, -1);
    chk("two model c10 tone", 32'(tl[10].tone), GAP_ON ? 0 : 100);
    chk("two model c10 busy", 32'(tl[10].busy), 1);
    chk("two model 2nd tone", 32'(tl[GAP_ON ? 15 : 12].tone), 200);
    chk("two model done idx", find_done(), GAP_ON ? 28 : 22);
    run(0, 1'b0, -1, 0, -1);

    // asynchronous reset mid-note (mid-gap when gaps are enabled)
    start_addr = '0;
    loop_en    = 1'b0;
    play       = 1'b1;
    @(posedge clk); #1;
    play = 1'b0;
    repeat (GAP_ON ? 11 : 5) @(posedge clk);
    #1;
    chk("pre-reset busy", 32'(busy), 1);
    chk("pre-reset oe",   32'(output_enable), GAP_ON ? 0 : 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset busy", 32'(busy), 0);
    chk("async reset oe",   32'(output_enable), 0);
    chk("async reset tone", 32'(tone_switch_period), 0);
    chk("async reset done", 32'(done), 0);
    chk("async reset addr", 32'(rom_addr), 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("no resume busy", 32'(busy), 0);
    chk("no resume addr", 32'(rom_addr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
